anti_droop_iir_mc: RTL and testbench

ANTI_DROOP_IIR_MC -- requirements
Module: anti_droop_iir_mc

---
 rtl/antidroop_pkg.sv | 39 +++
 rtl/antidroop_chan.sv | 104 ++++++++++
 rtl/anti_droop_iir_mc.sv | 62 ++++++
 tb/tb_anti_droop_iir_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/antidroop_pkg.sv
// antidroop_pkg: default parameters and saturation helpers for the
// anti-droop IIR datapath. No ports; imported by chan and top.
package antidroop_pkg;

  localparam int NCH_DEF       = 2;
  localparam int DW_DEF        = 16;
  localparam int TW_DEF        = 7;
  localparam int IIR_SCALE_DEF = 15;
  localparam int AW_DEF        = 48;

  // Clamp a sign-extended value to the signed range of width w.
  function automatic logic signed [127:0] sat_w(
    input logic signed [127:0] x,
    input int                  w
  );
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic signed [127:0] sat_DW(
    input logic signed [127:0] x,
    input int                  dw
  );
    return sat_w(x, dw);
  endfunction

  function automatic logic signed [127:0] sat_AW(
    input logic signed [127:0] x,
    input int                  aw
  );
    return sat_w(x, aw);
  endfunction

endpackage

// File: rtl/antidroop_chan.sv
// antidroop_chan: one channel of weighted-sum droop correction.
// Ports: clk_i/rst_i, clr_i (acc clear), oflow_clr_i, din_i, w_i,
// dout_o, oflow_now_o, oflow_sticky_o. Macro ANTIDROOP_PIPE_EN
// adds one input register ahead of the multiplier and summer.
module antidroop_chan
  import antidroop_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int TW        = TW_DEF,
  parameter int IIR_SCALE = IIR_SCALE_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 oflow_clr_i,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [TW-1:0] w_i,
  output logic signed [DW-1:0] dout_o,
  output logic                 oflow_now_o,
  output logic                 oflow_sticky_o
);

  localparam int MW  = DW + TW;
  localparam int SW  = AW + 1;
  localparam int SDW = DW + 1;
  localparam int CH  = IIR_SCALE + DW;

  localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [TW-1:0] w1_q, w2_q;
  logic signed [DW-1:0] din_q;
  logic signed [MW-1:0] mult_q, mult_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic                 on_q, on_d;
  logic                 st_q, st_d;

  logic signed [DW-1:0] src;
  logic signed [SW-1:0] sum;
  logic signed [DW-1:0] corr;
  logic signed [SDW-1:0] dsum;
  logic                 cov;

`ifdef ANTIDROOP_PIPE_EN
  logic signed [DW-1:0] din_p_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) din_p_q <= '0;
    else       din_p_q <= din_i;
  end

  assign src = din_p_q;
`else
  assign src = din_i;
`endif

  always_comb begin
    mult_d = MW'(src) * MW'(w2_q);
    sum    = SW'(acc_q) + SW'(mult_q);
    acc_d  = clr_i ? '0 : AW'(sat_AW(128'(sum), AW));
    corr   = acc_q[CH-1:IIR_SCALE];
    // Guard bit above the slice disagrees: slice cannot hold corr.
    cov    = acc_q[CH] ^ acc_q[CH-1];
    dsum   = SDW'(din_q) + SDW'(corr);
    if (cov) begin
      dout_d = acc_q[CH] ? DMIN : DMAX;
      on_d   = 1'b1;
    end else begin
      dout_d = DW'(sat_DW(128'(dsum), DW));
      on_d   = dsum[DW] ^ dsum[DW-1];
    end
    // Registered oflow_now sets the flag, so set beats a coincident clear.
    st_d = on_q | (st_q & ~oflow_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w1_q   <= '0;
      w2_q   <= '0;
      din_q  <= '0;
      mult_q <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      on_q   <= 1'b0;
      st_q   <= 1'b0;
    end else begin
      w1_q   <= w_i;
      w2_q   <= w1_q;
      din_q  <= src;
      mult_q <= mult_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      on_q   <= on_d;
      st_q   <= st_d;
    end
  end

  assign dout_o         = dout_q;
  assign oflow_now_o    = on_q;
  assign oflow_sticky_o = st_q;

endmodule

// File: rtl/anti_droop_iir_mc.sv
// anti_droop_iir_mc: multi-channel anti-droop IIR corrector.
// Ports: clk, rst, trig, acc_clr_en, din, tap_weight, oflow_clr,
// dout, oflow_now, oflow_sticky. Macro ANTIDROOP_PIPE_EN (in chan).
module anti_droop_iir_mc
  import antidroop_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int DW        = DW_DEF,
  parameter int TW        = TW_DEF,
  parameter int IIR_SCALE = IIR_SCALE_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              acc_clr_en,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH*TW-1:0] tap_weight,
  input  logic              oflow_clr,
  output logic [NCH*DW-1:0] dout,
  output logic [NCH-1:0]    oflow_now,
  output logic [NCH-1:0]    oflow_sticky
);

  logic trig_a_q, trig_b_q;
  logic trig_edge;
  logic acc_clr;

  // Two flops resynchronise the async trigger; edge detect on the pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_a_q <= 1'b0;
      trig_b_q <= 1'b0;
    end else begin
      trig_a_q <= trig;
      trig_b_q <= trig_a_q;
    end
  end

  assign trig_edge = trig_a_q & ~trig_b_q;
  assign acc_clr   = trig_edge & acc_clr_en;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    antidroop_chan #(
      .DW       (DW),
      .TW       (TW),
      .IIR_SCALE(IIR_SCALE),
      .AW       (AW)
    ) u_chan (
      .clk_i         (clk),
      .rst_i         (rst),
      .clr_i         (acc_clr),
      .oflow_clr_i   (oflow_clr),
      .din_i         (din[g*DW +: DW]),
      .w_i           (tap_weight[g*TW +: TW]),
      .dout_o        (dout[g*DW +: DW]),
      .oflow_now_o   (oflow_now[g]),
      .oflow_sticky_o(oflow_sticky[g])
    );
  end

endmodule

// File: tb/tb_anti_droop_iir_mc.sv
// tb_anti_droop_iir_mc: scoreboard bench with history-based model.
// Directed scenarios followed by randomized traffic.
module tb_anti_droop_iir_mc;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int TW  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              trig = 1'b0;
  logic              acc_clr_en = 1'b0;
  logic              oflow_clr = 1'b0;
  logic [NCH*DW-1:0] din = '0;
  logic [NCH*TW-1:0] tap_weight = '0;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    oflow_now;
  logic [NCH-1:0]    oflow_sticky;

  anti_droop_iir_mc dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .acc_clr_en  (acc_clr_en),
    .din         (din),
    .tap_weight  (tap_weight),
    .oflow_clr   (oflow_clr),
    .dout        (dout),
    .oflow_now   (oflow_now),
    .oflow_sticky(oflow_sticky)
  );

  typedef struct packed {
    logic [NCH*DW-1:0] d;
    logic [NCH-1:0]    on;
    logic [NCH-1:0]    st;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Model: running sum of x*w (w taken 3 inputs before x's successor),
  // plus input histories; a reset wipes every history.
  localparam longint AMAX = (64'sd1 <<< 47) - 1;
  localparam longint AMIN = -(64'sd1 <<< 47);
  longint m_acc[NCH];
  longint xh1[NCH], wh1[NCH], wh2[NCH], wh3[NCH];
  bit     on_p[NCH], st_p[NCH];
  bit     th1, th2;

  function automatic longint xin(int c);
    logic signed [DW-1:0] v;
    v = din[c*DW +: DW];
    return longint'(v);
  endfunction

  function automatic longint win(int c);
    logic signed [TW-1:0] v;
    v = tap_weight[c*TW +: TW];
    return longint'(v);
  endfunction

  function automatic logic signed [63:0] dch(int c);
    logic signed [DW-1:0] v;
    v = dout[c*DW +: DW];
    return 64'(v);
  endfunction

  task automatic model_step();
    exp_t e;
    bit te;
    longint pa, na, cf, t, corr, v;
    logic [63:0] bits;
    e = '0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; xh1[c] = 0;
        wh1[c] = 0; wh2[c] = 0; wh3[c] = 0;
        on_p[c] = 0; st_p[c] = 0;
      end
      th1 = 0; th2 = 0;
    end else begin
      te = th1 && !th2;
      for (int c = 0; c < NCH; c++) begin
        pa = m_acc[c];
        na = pa + xh1[c] * wh3[c];
        if (na > AMAX) na = AMAX;
        else if (na < AMIN) na = AMIN;
        if (te && acc_clr_en) na = 0;
        cf = pa >>> 15;
        t  = (pa >>> 30) & 3;
        if (t == 1 || t == 2) begin
          v = (t == 2) ? -32768 : 32767;
          e.on[c] = 1'b1;
        end else begin
          corr = ((cf + 32768) & 65535) - 32768;
          v = xh1[c] + corr;
          if (v > 32767) begin
            v = 32767; e.on[c] = 1'b1;
          end else if (v < -32768) begin
            v = -32768; e.on[c] = 1'b1;
          end
        end
        e.st[c] = on_p[c] | (st_p[c] & !oflow_clr);
        bits = v;
        e.d[c*DW +: DW] = bits[DW-1:0];
        m_acc[c] = na;
        on_p[c] = e.on[c];
        st_p[c] = e.st[c];
        wh3[c] = wh2[c]; wh2[c] = wh1[c]; wh1[c] = win(c);
        xh1[c] = xin(c);
      end
      th2 = th1;
      th1 = trig;
    end
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic setx(int c, int v);
    din[c*DW +: DW] = DW'(v);
  endtask

  task automatic setw(int c, int v);
    tap_weight[c*TW +: TW] = TW'(v);
  endtask

  task automatic chk(string n, logic signed [63:0] got,
                     logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int c = 0; c < NCH; c++) begin
          total++;
          if (dout[c*DW +: DW] !== e.d[c*DW +: DW]) begin
            bad++;
            $display("FAIL sb_dout ch%0d t=%0t got=%0d exp=%0d", c,
                     $time, $signed(dout[c*DW +: DW]),
                     $signed(e.d[c*DW +: DW]));
          end
        end
        total++;
        if (oflow_now !== e.on) begin
          bad++;
          $display("FAIL sb_on t=%0t got=%b exp=%b", $time,
                   oflow_now, e.on);
        end
        total++;
        if (oflow_sticky !== e.st) begin
          bad++;
          $display("FAIL sb_st t=%0t got=%b exp=%b", $time,
                   oflow_sticky, e.st);
        end
      end
    end
  end

  initial begin
    logic signed [63:0] prev;
    bit found;

    rst = 1'b1;
    repeat (2) cyc();
    chk("rst_dout", dout, 0);
    chk("rst_on", oflow_now, 0);
    chk("rst_st", oflow_sticky, 0);

    rst = 1'b0;
    setw(0, 63); setw(1, 0);
    setx(0, 1000); setx(1, 0);
    repeat (5) cyc();
    chk("acc1", dch(0), 1001);
    repeat (9) cyc();
    chk("acc10", dch(0), 1019);
    chk("ch1_idle", dch(1), 0);

    trig = 1'b1; acc_clr_en = 1'b1;
    repeat (3) cyc();
    chk("clr_ret", dch(0), 1000);
    repeat (2) cyc();
    chk("clr_once", dch(0), 1003);
    trig = 1'b0; acc_clr_en = 1'b0;
    repeat (2) cyc();
    prev = dch(0);
    trig = 1'b1;
    repeat (3) cyc();
    chk("clr_dis", dch(0) > prev, 1);
    trig = 1'b0;

    rst = 1'b1; cyc(); rst = 1'b0;
    setx(0, 32000); setw(0, 63); setx(1, 0); setw(1, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (dch(0) == 32767) found = 1;
    end
    chk("sat_reach", found, 1);
    chk("sat_on", oflow_now[0], 1);
    oflow_clr = 1'b1;
    cyc();
    chk("st_setwins", oflow_sticky[0], 1);
    setx(0, 0); setw(0, 0);
    repeat (3) cyc();
    chk("st_clr", oflow_sticky[0], 0);
    chk("on_clr", oflow_now[0], 0);
    oflow_clr = 1'b0;

    rst = 1'b1; cyc(); rst = 1'b0;
    setw(0, 63); setw(1, -63);
    setx(0, 1000); setx(1, 1000);
    repeat (14) cyc();
    chk("xch0", dch(0), 1019);
    chk("xch1", dch(1), 980);

    rst = 1'b1; cyc();
    chk("mid_rst_d", dout, 0);
    chk("mid_rst_on", oflow_now, 0);
    chk("mid_rst_st", oflow_sticky, 0);
    rst = 1'b0;
    setx(0, 500); setx(1, 500);
    repeat (2) cyc();
    chk("post_rst0", dch(0), 500);
    chk("post_rst1", dch(1), 500);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) trig = ~trig;
      acc_clr_en = 1'($urandom_range(0, 1));
      oflow_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0)
        for (int c = 0; c < NCH; c++)
          setw(c, int'($urandom_range(0, 127)));
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0)
          setx(c, int'($urandom_range(30000, 32767)));
        else
          setx(c, int'($urandom_range(0, 65535)));
      end
      cyc();
    end

    rst = 1'b0; trig = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
